// File: rtl/systolic_skew_feeder_pkg.sv
// ---------------------------------------------------------------------------
// systolic_pkg
//   Definitions shared by the systolic operand feeder and its buffers:
//   default array geometry, the feeder state encoding and an index-width
//   helper.
// ---------------------------------------------------------------------------
package systolic_pkg;

    localparam int N_DEF          = 4;  // default array dimension
    localparam int DATA_WIDTH_DEF = 8;  // default operand width

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        STREAM,
        DONE
    } feeder_state_t;

    // Width of an index into a table of 'depth' entries (at least one bit).
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/systolic_skew_feeder_vec_buf.sv
// ---------------------------------------------------------------------------
// feeder_vec_buf
//   DEPTH x (LANES*DW) register array holding one operand vector per slot.
//   One full-width write port; LANES independent read ports, where read port
//   l returns lane l of the slot selected by its own index. A read of the
//   slot being written in the same cycle returns the incoming data, so a
//   vector can be replayed on the edge that stores it.
//
//   Ports
//     clk    in   clock
//     we     in   write enable
//     waddr  in   AW        write slot
//     wdata  in   LANES*DW  write vector, lane 0 in the LSBs
//     raddr  in   LANES*AW  per-lane read slot, lane 0 in the LSBs
//     rdata  out  LANES*DW  lane l = slot raddr[l], lane l
// ---------------------------------------------------------------------------
module feeder_vec_buf
    import systolic_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int LANES = N_DEF,
    parameter int DW    = DATA_WIDTH_DEF,
    parameter int AW    = idx_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [LANES*DW-1:0]   wdata,
    input  logic [LANES*AW-1:0]   raddr,
    output logic [LANES*DW-1:0]   rdata
);

    logic [LANES*DW-1:0] mem_q [DEPTH];

    // NOTE: the storage has no reset; every slot is written in LOAD before
    // STREAM reads it, so a reset would only add a reset net to each bit.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata = '0;
        for (int l = 0; l < LANES; l++) begin
            if (we && (raddr[l*AW +: AW] == waddr)) begin
                rdata[l*DW +: DW] = wdata[l*DW +: DW];
            end else begin
                rdata[l*DW +: DW] = mem_q[raddr[l*AW +: AW]][l*DW +: DW];
            end
        end
    end

endmodule

// File: rtl/systolic_skew_feeder.sv
// ---------------------------------------------------------------------------
// systolic_skew_feeder
//   Operand transmitter for an N x N output-stationary MAC systolic array.
//   Collects K column vectors of A and K row vectors of B through a joint
//   valid/ready handshake, then replays them diagonally skewed: lane i of
//   left_out carries A[i][t-i], lane j of top_out carries B[t-j][j], zero
//   outside the valid window. Drives the array strobes and pulses done when
//   every accumulator holds its final C[i][j].
//
//   Sequence: IDLE -> CLEAR (1 cycle) -> LOAD (K beats) ->
//             STREAM (K+2N-2 cycles) -> DONE (1 cycle) -> IDLE
//
//   Ports
//     clk, rst        clock; synchronous active-high reset
//     start, k_len    job request and inner dimension (sampled in IDLE)
//     a_valid/a_ready/a_data   A column stream, lane i = A[i][k]
//     b_valid/b_ready/b_data   B row stream,    lane j = B[k][j]
//     left_out        lane i -> in_left of array row i
//     top_out         lane j -> in_top of array column j
//     shift_en, acc_en, acc_rst   array strobes
//     busy            not IDLE
//     done            one-cycle pulse, array results valid
//     stall_cnt       (SKEW_FEEDER_STALL_CNT_EN only) LOAD cycles without a
//                     beat transfer, saturating
//
//   Build option: define SKEW_FEEDER_STALL_CNT_EN to add stall_cnt.
// ---------------------------------------------------------------------------
module systolic_skew_feeder
    import systolic_pkg::*;
#(
    parameter int N          = N_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int MAX_K      = 16,
    parameter int KW         = $clog2(MAX_K + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [KW-1:0]           k_len,
    input  logic                    a_valid,
    output logic                    a_ready,
    input  logic [N*DATA_WIDTH-1:0] a_data,
    input  logic                    b_valid,
    output logic                    b_ready,
    input  logic [N*DATA_WIDTH-1:0] b_data,
    output logic [N*DATA_WIDTH-1:0] left_out,
    output logic [N*DATA_WIDTH-1:0] top_out,
    output logic                    shift_en,
    output logic                    acc_en,
    output logic                    acc_rst,
    output logic                    busy,
    output logic                    done
`ifdef SKEW_FEEDER_STALL_CNT_EN
    ,
    output logic [31:0]             stall_cnt
`endif
);

    localparam int VW = N * DATA_WIDTH;
    localparam int AW = idx_width(MAX_K);
    // Step counter reaches K+2N-3 at most.
    localparam int TW = $clog2(MAX_K + 2 * N);

    feeder_state_t   state_q, state_d;
    logic [KW-1:0]   klen_q, klen_d;
    logic [AW-1:0]   k_q, k_d;
    logic [TW-1:0]   t_q, t_d;
    logic [VW-1:0]   left_q, left_d;
    logic [VW-1:0]   top_q, top_d;
    logic            shift_en_q, shift_en_d;
    logic            acc_en_q, acc_en_d;
    logic            acc_rst_q, acc_rst_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            start_ok;
    logic            xfer;
    logic            load_last;
    logic            stream_last;
    logic [N*AW-1:0] rd_idx;
    logic [N-1:0]    lane_live;
    logic [VW-1:0]   a_rdata;
    logic [VW-1:0]   b_rdata;

    // Joint handshake: each side is ready only when the other side is
    // valid, so A and B beats always transfer together.
    assign a_ready = (state_q == LOAD) && b_valid;
    assign b_ready = (state_q == LOAD) && a_valid;

    // ------------------------------------------------------------------
    // Next-state and counter logic
    // ------------------------------------------------------------------
    // NOTE: every signal of an always_comb gets a default on entry, so no
    // path through the case statement can leave it unassigned (latch).
    always_comb begin
        state_d = state_q;
        klen_d  = klen_q;
        k_d     = k_q;
        t_d     = t_q;

        start_ok    = start && (k_len != '0) && (k_len <= KW'(MAX_K));
        xfer        = (state_q == LOAD) && a_valid && b_valid;
        load_last   = ((KW'(k_q) + KW'(1)) == klen_q);
        stream_last = (t_q == (TW'(klen_q) + TW'(2 * N - 3)));

        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = CLEAR;
                    klen_d  = k_len;
                end
            end
            CLEAR: begin
                state_d = LOAD;
                k_d     = '0;
            end
            LOAD: begin
                if (xfer) begin
                    if (load_last) begin
                        state_d = STREAM;
                        k_d     = '0;
                        t_d     = '0;
                    end else begin
                        k_d = k_q + AW'(1);
                    end
                end
            end
            STREAM: begin
                if (stream_last) begin
                    state_d = DONE;
                end else begin
                    t_d = t_q + TW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Strobes are decoded from the next state so the registered outputs
    // line up with the cycle the state machine is in.
    always_comb begin
        busy_d     = (state_d != IDLE);
        acc_rst_d  = (state_d == CLEAR);
        shift_en_d = (state_d == CLEAR) || (state_d == STREAM);
        acc_en_d   = (state_d == STREAM);
        done_d     = (state_d == DONE);
    end

    // ------------------------------------------------------------------
    // Skew window: lane i replays slot t-i while 0 <= t-i < K. A and B
    // share the same per-lane slot index (row i / column j use t-i / t-j).
    // ------------------------------------------------------------------
    always_comb begin
        rd_idx    = '0;
        lane_live = '0;
        for (int i = 0; i < N; i++) begin
            if ((state_d == STREAM) && (t_d >= TW'(i)) &&
                ((t_d - TW'(i)) < TW'(klen_q))) begin
                lane_live[i]         = 1'b1;
                rd_idx[i*AW +: AW]   = AW'(t_d - TW'(i));
            end
        end
    end

    always_comb begin
        left_d = '0;
        top_d  = '0;
        for (int i = 0; i < N; i++) begin
            if (lane_live[i]) begin
                left_d[i*DATA_WIDTH +: DATA_WIDTH] = a_rdata[i*DATA_WIDTH +: DATA_WIDTH];
                top_d[i*DATA_WIDTH +: DATA_WIDTH]  = b_rdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    feeder_vec_buf #(
        .DEPTH (MAX_K),
        .LANES (N),
        .DW    (DATA_WIDTH),
        .AW    (AW)
    ) u_a_buf (
        .clk   (clk),
        .we    (xfer),
        .waddr (k_q),
        .wdata (a_data),
        .raddr (rd_idx),
        .rdata (a_rdata)
    );

    feeder_vec_buf #(
        .DEPTH (MAX_K),
        .LANES (N),
        .DW    (DATA_WIDTH),
        .AW    (AW)
    ) u_b_buf (
        .clk   (clk),
        .we    (xfer),
        .waddr (k_q),
        .wdata (b_data),
        .raddr (rd_idx),
        .rdata (b_rdata)
    );

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            klen_q     <= '0;
            k_q        <= '0;
            t_q        <= '0;
            left_q     <= '0;
            top_q      <= '0;
            shift_en_q <= 1'b0;
            acc_en_q   <= 1'b0;
            acc_rst_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            klen_q     <= klen_d;
            k_q        <= k_d;
            t_q        <= t_d;
            left_q     <= left_d;
            top_q      <= top_d;
            shift_en_q <= shift_en_d;
            acc_en_q   <= acc_en_d;
            acc_rst_q  <= acc_rst_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign left_out = left_q;
    assign top_out  = top_q;
    assign shift_en = shift_en_q;
    assign acc_en   = acc_en_q;
    assign acc_rst  = acc_rst_q;
    assign busy     = busy_q;
    assign done     = done_q;

`ifdef SKEW_FEEDER_STALL_CNT_EN
    // LOAD cycles without a beat transfer; cleared by an accepted start,
    // saturating, and held through DONE/IDLE for software to read.
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == IDLE) && start_ok) begin
            stall_cnt_d = '0;
        end else if ((state_q == LOAD) && !xfer && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
`timescale 1ns/1ps
module tb_systolic_skew_feeder;

    localparam int DW = 8;
    localparam int MK = 16;
    localparam int KW = $clog2(MK + 1);
    localparam int N2 = 2;
    localparam int N4 = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- N=2 instance ----------------
    logic              start2, a_valid2, b_valid2;
    logic [KW-1:0]     klen2;
    logic [N2*DW-1:0]  a_data2, b_data2, left2, top2;
    logic              a_ready2, b_ready2, shift2, accen2, accrst2, busy2, done2;
`ifdef SKEW_FEEDER_STALL_CNT_EN
    logic [31:0]       stall2;
`endif

    systolic_skew_feeder #(.N(N2), .DATA_WIDTH(DW), .MAX_K(MK)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .k_len(klen2),
        .a_valid(a_valid2), .a_ready(a_ready2), .a_data(a_data2),
        .b_valid(b_valid2), .b_ready(b_ready2), .b_data(b_data2),
        .left_out(left2), .top_out(top2), .shift_en(shift2), .acc_en(accen2),
        .acc_rst(accrst2), .busy(busy2), .done(done2)
`ifdef SKEW_FEEDER_STALL_CNT_EN
        , .stall_cnt(stall2)
`endif
    );

    // ---------------- N=4 instance ----------------
    logic              start4, a_valid4, b_valid4;
    logic [KW-1:0]     klen4;
    logic [N4*DW-1:0]  a_data4, b_data4, left4, top4;
    logic              a_ready4, b_ready4, shift4, accen4, accrst4, busy4, done4;
`ifdef SKEW_FEEDER_STALL_CNT_EN
    logic [31:0]       stall4;
`endif

    systolic_skew_feeder #(.N(N4), .DATA_WIDTH(DW), .MAX_K(MK)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .k_len(klen4),
        .a_valid(a_valid4), .a_ready(a_ready4), .a_data(a_data4),
        .b_valid(b_valid4), .b_ready(b_ready4), .b_data(b_data4),
        .left_out(left4), .top_out(top4), .shift_en(shift4), .acc_en(accen4),
        .acc_rst(accrst4), .busy(busy4), .done(done4)
`ifdef SKEW_FEEDER_STALL_CNT_EN
        , .stall_cnt(stall4)
`endif
    );

    // ------------- behavioural MAC arrays driven by each feeder -------------
    logic signed [31:0]   c2 [N2][N2];
    logic signed [DW-1:0] ar2 [N2][N2];
    logic signed [DW-1:0] br2 [N2][N2];

    always @(posedge clk) begin
        for (int i = 0; i < N2; i++) begin
            for (int j = 0; j < N2; j++) begin
                logic signed [DW-1:0] ai, bi;
                ai = (j == 0) ? $signed(left2[i*DW +: DW]) : ar2[i][(j == 0) ? 0 : j-1];
                bi = (i == 0) ? $signed(top2[j*DW +: DW])  : br2[(i == 0) ? 0 : i-1][j];
                if (rst) begin
                    c2[i][j] <= 0; ar2[i][j] <= 0; br2[i][j] <= 0;
                end else begin
                    if (accrst2)     c2[i][j] <= 0;
                    else if (accen2) c2[i][j] <= c2[i][j] + ai * bi;
                    if (shift2) begin ar2[i][j] <= ai; br2[i][j] <= bi; end
                end
            end
        end
    end

    logic signed [31:0]   c4 [N4][N4];
    logic signed [DW-1:0] ar4 [N4][N4];
    logic signed [DW-1:0] br4 [N4][N4];

    always @(posedge clk) begin
        for (int i = 0; i < N4; i++) begin
            for (int j = 0; j < N4; j++) begin
                logic signed [DW-1:0] ai, bi;
                ai = (j == 0) ? $signed(left4[i*DW +: DW]) : ar4[i][(j == 0) ? 0 : j-1];
                bi = (i == 0) ? $signed(top4[j*DW +: DW])  : br4[(i == 0) ? 0 : i-1][j];
                if (rst) begin
                    c4[i][j] <= 0; ar4[i][j] <= 0; br4[i][j] <= 0;
                end else begin
                    if (accrst4)     c4[i][j] <= 0;
                    else if (accen4) c4[i][j] <= c4[i][j] + ai * bi;
                    if (shift4) begin ar4[i][j] <= ai; br4[i][j] <= bi; end
                end
            end
        end
    end

    // ---------------- N=4 scoreboard ----------------
    typedef struct packed {
        logic [N4*DW-1:0] left;
        logic [N4*DW-1:0] top;
    } lanes_t;

    lanes_t sb[$];
    logic [DW-1:0] ma [MK][N4];   // ma[k][i] = A[i][k]
    logic [DW-1:0] mb [MK][N4];   // mb[k][j] = B[k][j]
    int done4_cnt = 0, done4_cyc = 0, accrst4_cnt = 0, accen4_cnt = 0;

    always @(negedge clk) begin
        lanes_t e;
        if (accen4) begin
            accen4_cnt++;
            if (sb.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                e = sb.pop_front();
                check("lanes4", {left4, top4}, e);
            end
        end
        if (done4) begin done4_cnt++; done4_cyc = cyc; end
        if (accrst4) accrst4_cnt++;
    end

    task automatic push_expected(input int k);
        for (int t = 0; t < k + 2*N4 - 2; t++) begin
            lanes_t e;
            e = '0;
            for (int i = 0; i < N4; i++) begin
                if (t - i >= 0 && t - i < k) begin
                    e.left[i*DW +: DW] = ma[t-i][i];
                    e.top[i*DW +: DW]  = mb[t-i][i];
                end
            end
            sb.push_back(e);
        end
    endtask

    function automatic logic [N4*DW-1:0] pack_a(input int k);
        logic [N4*DW-1:0] r;
        for (int i = 0; i < N4; i++) r[i*DW +: DW] = ma[k][i];
        return r;
    endfunction

    function automatic logic [N4*DW-1:0] pack_b(input int k);
        logic [N4*DW-1:0] r;
        for (int j = 0; j < N4; j++) r[j*DW +: DW] = mb[k][j];
        return r;
    endfunction

    task automatic fill(input int mode);
        for (int k = 0; k < MK; k++) begin
            for (int i = 0; i < N4; i++) begin
                case (mode)
                    0:       begin ma[k][i] = 8'h01; mb[k][i] = 8'h01; end
                    1:       begin ma[k][i] = 8'hFF; mb[k][i] = 8'hFF; end
                    default: begin ma[k][i] = 8'($urandom); mb[k][i] = 8'($urandom); end
                endcase
            end
        end
    endtask

    task automatic check_c4(input int k, input string tag);
        for (int i = 0; i < N4; i++) begin
            for (int j = 0; j < N4; j++) begin
                int s;
                s = 0;
                for (int kk = 0; kk < k; kk++)
                    s += int'($signed(ma[kk][i])) * int'($signed(mb[kk][j]));
                check($sformatf("%s_c%0d%0d", tag, i, j), c4[i][j], s);
            end
        end
    endtask

    // Full job on the N=4 feeder: b_valid held low for the first stall_len
    // LOAD cycles; poke pulses start during LOAD and during STREAM.
    task automatic run4(input int k, input int stall_len, input bit poke, input string tag);
        int beat, n, start_cyc, d0, r0, e0;
        d0 = done4_cnt; r0 = accrst4_cnt; e0 = accen4_cnt;
        klen4 = KW'(k); start4 = 1'b1; start_cyc = cyc;
        push_expected(k);
        @(negedge clk); start4 = 1'b0;
        @(negedge clk);
        beat = 0; n = 0;
        while (beat < k && n < 500) begin
            a_valid4 = 1'b1; b_valid4 = (n >= stall_len);
            a_data4 = pack_a(beat); b_data4 = pack_b(beat);
            start4 = poke && (n == 0);
            #1;
            if (n < stall_len) check({tag, "_stall_a_ready"}, a_ready4, 0);
            if (a_ready4 && b_ready4) beat++;
            @(negedge clk); n++;
        end
        a_valid4 = 1'b0; b_valid4 = 1'b0; start4 = 1'b0;
        n = 0;
        while (done4_cnt == d0 && n < 200) begin
            start4 = poke && (n == 2);
            @(negedge clk); n++;
        end
        start4 = 1'b0;
        @(negedge clk); @(negedge clk);
        check({tag, "_done_count"}, done4_cnt - d0, 1);
        check({tag, "_latency"}, done4_cyc - start_cyc, 2 + 2*k + 2*N4 - 2 + stall_len);
        check({tag, "_acc_rst_count"}, accrst4_cnt - r0, 1);
        check({tag, "_stream_len"}, accen4_cnt - e0, k + 2*N4 - 2);
        check({tag, "_sb_empty"}, sb.size(), 0);
        check({tag, "_busy_after"}, busy4, 0);
        check_c4(k, tag);
    endtask

    // ---------------- table for the basic N=2 job ----------------
    typedef struct {
        logic             start;
        logic             av;
        logic [15:0]      ad;
        logic             bv;
        logic [15:0]      bd;
        logic [37:0]      exp;   // {busy,acc_rst,shift_en,acc_en,done,a_ready,left,top}
    } vec_t;

    function automatic vec_t mk(input logic s, input logic av, input logic [15:0] ad,
                                input logic bv, input logic [15:0] bd,
                                input logic [5:0] ctl, input logic [15:0] l, input logic [15:0] t);
        vec_t v;
        v.start = s; v.av = av; v.ad = ad; v.bv = bv; v.bd = bd;
        v.exp = {ctl, l, t};
        return v;
    endfunction

    vec_t tv [10];

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, s0;
        start2 = 0; klen2 = '0; a_valid2 = 0; b_valid2 = 0; a_data2 = '0; b_data2 = '0;
        start4 = 0; klen4 = '0; a_valid4 = 0; b_valid4 = 0; a_data4 = '0; b_data4 = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset4_lanes", {left4, top4}, 0);
        check("reset4_ctl", {a_ready4, b_ready4, shift4, accen4, accrst4, busy4, done4}, 0);

        // Basic job: start in cycle 0, beats in cycles 2-3, done in cycle 8.
        tv[0] = mk(1, 0, 16'h0000, 0, 16'h0000, 6'b000000, 16'h0000, 16'h0000);
        tv[1] = mk(0, 0, 16'h0000, 0, 16'h0000, 6'b111000, 16'h0000, 16'h0000);
        tv[2] = mk(0, 1, 16'h0301, 1, 16'h0605, 6'b100001, 16'h0000, 16'h0000);
        tv[3] = mk(0, 1, 16'h0402, 1, 16'h0807, 6'b100001, 16'h0000, 16'h0000);
        tv[4] = mk(0, 0, 16'h0000, 0, 16'h0000, 6'b101100, 16'h0001, 16'h0005);
        tv[5] = mk(0, 0, 16'h0000, 0, 16'h0000, 6'b101100, 16'h0302, 16'h0607);
        tv[6] = mk(0, 0, 16'h0000, 0, 16'h0000, 6'b101100, 16'h0400, 16'h0800);
        tv[7] = mk(0, 0, 16'h0000, 0, 16'h0000, 6'b101100, 16'h0000, 16'h0000);
        tv[8] = mk(0, 0, 16'h0000, 0, 16'h0000, 6'b100010, 16'h0000, 16'h0000);
        tv[9] = mk(0, 0, 16'h0000, 0, 16'h0000, 6'b000000, 16'h0000, 16'h0000);
        for (int r = 0; r < 10; r++) begin
            start2 = tv[r].start; klen2 = KW'(2);
            a_valid2 = tv[r].av; a_data2 = tv[r].ad;
            b_valid2 = tv[r].bv; b_data2 = tv[r].bd;
            #1;
            check($sformatf("basic_cyc%0d", r),
                  {busy2, accrst2, shift2, accen2, done2, a_ready2, left2, top2}, tv[r].exp);
            @(negedge clk);
        end
        check("basic_c00", c2[0][0], 19);
        check("basic_c01", c2[0][1], 22);
        check("basic_c10", c2[1][0], 43);
        check("basic_c11", c2[1][1], 50);

        // Same job with b_valid low in LOAD cycles 2-4.
        s0 = cyc; start2 = 1'b1; klen2 = KW'(2);
        @(negedge clk); start2 = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            a_valid2 = 1'b1;
            a_data2  = (k == 4) ? 16'h0402 : 16'h0301;
            b_valid2 = (k >= 3);
            b_data2  = (k == 4) ? 16'h0807 : 16'h0605;
            #1;
            if (k < 3) check($sformatf("stall2_a_ready_%0d", k), a_ready2, 0);
            @(negedge clk);
        end
        a_valid2 = 1'b0; b_valid2 = 1'b0;
        n = 0;
        while (!done2 && n < 50) begin @(negedge clk); n++; end
        check("stall2_done_cycle", cyc - s0, 11);
        check("stall2_c00", c2[0][0], 19);
        check("stall2_c11", c2[1][1], 50);
`ifdef SKEW_FEEDER_STALL_CNT_EN
        check("stall2_cnt", stall2, 3);
`endif

        // Invalid starts on the N=4 feeder.
        start4 = 1'b1; klen4 = '0;
        @(negedge clk);
        check("inv_k0", {busy4, shift4, accen4, accrst4, done4}, 0);
        klen4 = KW'(MK + 1);
        @(negedge clk);
        check("inv_k17", {busy4, shift4, accen4, accrst4, done4}, 0);
        start4 = 1'b0;
        @(negedge clk);
        check("inv_idle", {busy4, shift4, accen4, accrst4, done4}, 0);

        fill(0); run4(MK, 0, 0, "maxk_ones");
        fill(1); run4(MK, 0, 0, "maxk_ff");
        fill(2); run4(5, 2, 1, "busy_poke");
        fill(2); run4(1, 0, 0, "k1");

        // Reset during STREAM step t=2.
        fill(2);
        klen4 = KW'(3); start4 = 1'b1; push_expected(3);
        @(negedge clk); start4 = 1'b0;
        @(negedge clk);
        for (int b = 0; b < 3; b++) begin
            a_valid4 = 1'b1; b_valid4 = 1'b1; a_data4 = pack_a(b); b_data4 = pack_b(b);
            @(negedge clk);
        end
        a_valid4 = 1'b0; b_valid4 = 1'b0;
        @(negedge clk); @(negedge clk);
        check("rstmid_in_stream", accen4, 1);
        n = done4_cnt;
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_lanes", {left4, top4}, 0);
        check("rstmid_ctl", {a_ready4, b_ready4, shift4, accen4, accrst4, busy4, done4}, 0);
        rst = 1'b0;
        sb.delete();
        repeat (12) @(negedge clk);
        check("rstmid_no_done", done4_cnt - n, 0);
        fill(2); run4(4, 0, 0, "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
- Operand transmitter for the N×N MAC-cell systolic array.
- Accepts K column-vectors of A and K row-vectors of B over valid/ready streams and buffers them locally.
- Replays them diagonally skewed into the array's left edge (in_left of column 0, per row) and top edge (in_top of row 0, per column).
- Generates the array control strobes acc_rst, acc_en and shift_en, and signals done when every cell's accumulator holds its final C[i][j].

Parameters:
- N, 4, array dimension (rows = columns = lanes); must be ≥2.
- DATA_WIDTH, 8, operand width; matches the cell operand width.
- MAX_K, 16, buffer depth; the maximum inner dimension K.
- KW, $clog2(MAX_K+1), width of k_len.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  begin a job; sampled only in IDLE.
- k_len  in  KW  inner dimension K for the job; sampled with start.
- a_valid  in  1  A beat valid.
- a_ready  out  1  A beat accepted.
- a_data  in  N*DATA_WIDTH  A column k; lane i = A[i][k], lane 0 in the LSBs.
- b_valid  in  1  B beat valid.
- b_ready  out  1  B beat accepted.
- b_data  in  N*DATA_WIDTH  B row k; lane j = B[k][j].
- left_out  out  N*DATA_WIDTH  lane i drives in_left of array row i.
- top_out  out  N*DATA_WIDTH  lane j drives in_top of array column j.
- shift_en  out  1  array shift strobe.
- acc_en  out  1  array accumulate strobe.
- acc_rst  out  1  array accumulator clear.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse; array results are valid.

Behaviour:
- Reset values:
  - State returns to IDLE.
  - All outputs are 0, including a_ready, b_ready, left_out, top_out and all strobes.
  - Buffer contents are don't-care.
- States: IDLE → CLEAR → LOAD → STREAM → DONE → IDLE.
- IDLE:
  - start with 1 ≤ k_len ≤ MAX_K latches K and moves to CLEAR.
  - start with k_len = 0 or k_len > MAX_K is ignored; the block stays in IDLE.
- CLEAR: lasts one cycle.
  - acc_rst=1 and shift_en=1.
  - left_out and top_out are 0, which flushes the cell pipeline registers.
- LOAD:
  - a_ready = b_valid and b_ready = a_valid. This is a joint handshake, so a beat never transfers on only one side.
  - A beat transfers when a_valid && b_valid. It is written to buffer slot k, and k increments.
  - When beat K-1 transfers, the block moves to STREAM on the next cycle and k resets to 0.
  - Back-pressure is unlimited.
- STREAM: lasts exactly K+2N-2 cycles, with step counter t = 0..K+2N-3.
  - shift_en=1 and acc_en=1 on every cycle.
  - left_out lane i = A[i][t-i] when 0 ≤ t-i < K, otherwise 0.
  - top_out lane j = B[t-j][j] when 0 ≤ t-j < K, otherwise 0.
  - Operands are registered outputs, valid in the cycle that t indexes.
  - The zero padding makes acc_en safe outside the useful window.
  - The final product lands in cell (N-1,N-1) on the clock edge that ends step t = K+2N-3.
- DONE: lasts one cycle.
  - done=1, all strobes 0, lanes 0.
  - Next state is IDLE.
  - start is not accepted in this cycle.
- Latency:
  - start → CLEAR is 1 cycle.
  - With no stalls, done arrives at start+2+K+(K+2N-2).
- start while busy is ignored.
- rst mid-job aborts the job immediately with no done pulse. The array's own reset is required to restore cell state.
- Arithmetic: buffers and lanes are raw DATA_WIDTH bits with no sign handling; the cells interpret them as signed.

Optional Feature:
- Macro: SKEW_FEEDER_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt (32 bits).
  - stall_cnt counts LOAD cycles in which no beat transferred.
  - It clears to 0 on an accepted start and on rst, and saturates at 2^32-1.
  - It holds its value after done.
- Undefined: the port and the counter are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package systolic_pkg holds:
  - Default constants N_DEF and DATA_WIDTH_DEF.
  - feeder_state_t enum {IDLE, CLEAR, LOAD, STREAM, DONE}.
- One sub-module: feeder_vec_buf, a MAX_K × N*DATA_WIDTH register array with one write port and N independent per-lane read indices. It is instantiated twice, once for A and once for B.

Test Plan:
- Basic job, N=2, K=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]]:
  - Stimulus: start at cycle 0; beats {3,1},{4,2} on A and {6,5},{8,7} on B, both presented at cycles 2-3.
  - left lane 0 = 1,2,0,0 and lane 1 = 0,3,4,0.
  - top lane 0 = 5,7,0,0 and lane 1 = 0,6,8,0.
  - acc_rst at cycle 1, done at cycle 8, and an attached array holds C=[[19,22],[43,50]].
- Stall: same job, with b_valid low during cycles 2-4.
  - No A beat transfers during the stall, and a_ready stays 0.
  - done shifts exactly 3 cycles later.
  - With the macro defined, stall_cnt=3.
- Invalid start: start with k_len=0, then k_len=MAX_K+1.
  - busy stays 0 and no strobes are driven.
  - A following valid start runs normally.
- Maximum K: K=MAX_K=16, N=4, all operands = 0x01.
  - STREAM lasts 22 cycles.
  - Every C[i][j]=16.
  - Signed check: all operands = 0xFF gives C=16.
- Reset mid-job: assert rst at stream step t=2.
  - Next cycle: all outputs are 0 and busy=0, with no done pulse.
  - A new job then completes correctly.
- Start while busy: pulse start during LOAD and again during STREAM.
  - Both are ignored, with no extra acc_rst.
  - Exactly one done pulse is produced.
